data_mem_arbiter: RTL and testbench



---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 102 ++++++++++
 tb/tb_data_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the core, the auxiliary port and data_memory.
// The slave modport is the arbiter's view, the master modport the environment's.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  // core port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_stall;
  logic [DATA_W-1:0] c_rdata;
  logic              c_rvalid;
  // auxiliary port
  logic              a_req;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  // memory side
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  mem_rdata,
    output c_gnt, c_stall, c_rdata, c_rvalid,
    output a_gnt, a_rdata, a_rvalid,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output mem_rdata,
    input  c_gnt, c_stall, c_rdata, c_rvalid,
    input  a_gnt, a_rdata, a_rvalid,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: core has priority, aux is protected from
// starvation by a saturating denial counter and may take bounded locked bursts.
module data_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input logic               CLK,
  input logic               RST_N,
  data_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BLAST = BW'(BURST_MAX - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            rd_c_q, rd_c_d;
  logic            rd_a_q, rd_a_d;
  logic            c_gnt, a_gnt, in_burst, starved;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  // Grant decision; while reset is held the IDLE rule applies regardless of state.
  always_comb begin
    in_burst = (state_q == BURST) && RST_N;
    starved  = (starve_q == SMAX);
    if (in_burst) begin
      a_gnt = bus.a_req;
      c_gnt = 1'b0;
    end else begin
      a_gnt = bus.a_req && (!bus.c_req || starved);
      c_gnt = bus.c_req && !a_gnt;
    end
  end

  // Next-state: burst tracking, starvation counter, read tags.
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    starve_d = (bus.a_req && !a_gnt) ? (starved ? starve_q : starve_q + SW'(1)) : '0;
    rd_c_d   = c_gnt & ~bus.c_we;
    rd_a_d   = a_gnt & ~bus.a_we;
    case (state_q)
      IDLE: begin
        // a cap of one grant never needs the burst state
        if (a_gnt && bus.a_lock && (BURST_MAX > 1)) begin
          state_d = BURST;
          burst_d = BW'(1);
        end
      end
      BURST: begin
        // in BURST a_gnt == a_req, so the cap test implies this grant completes
        if (!bus.a_lock || !bus.a_req || (burst_q == BLAST)) begin
          state_d  = IDLE;
          burst_d  = '0;
          starve_d = '0;
        end else begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      starve_q <= '0;
      burst_q  <= '0;
      rd_c_q   <= 1'b0;
      rd_a_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
      rd_c_q   <= rd_c_d;
      rd_a_q   <= rd_a_d;
    end
  end

  // With no grant the memory bus idles on the core's fields.
  assign mux_addr  = a_gnt ? bus.a_addr  : bus.c_addr;
  assign mux_wdata = a_gnt ? bus.a_wdata : bus.c_wdata;

  assign bus.mem_addr  = mux_addr;
  assign bus.mem_wdata = mux_wdata;
  assign bus.mem_we    = RST_N & (a_gnt ? bus.a_we : (c_gnt & bus.c_we));
  assign bus.c_gnt     = c_gnt;
  assign bus.a_gnt     = a_gnt;
  assign bus.c_stall   = bus.c_req & ~c_gnt;
  assign bus.c_rdata   = bus.mem_rdata;
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.c_rvalid  = rd_c_q;
  assign bus.a_rvalid  = rd_a_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand sequences for reset
// mid-burst, and random traffic against a behavioural arbitration model.
module tb_data_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int SMAX = 4;
  localparam int BMAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX))
    dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  // registered single-port memory; read-before-write on the same edge
  logic [DW-1:0] tmem [1024];
  always @(posedge clk) begin
    if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= tmem[bus.mem_addr];
  end

  typedef struct {
    bit rst_n, c_req, c_we;
    bit [AW-1:0] c_addr;
    bit [DW-1:0] c_wdata;
    bit a_req, a_we, a_lock;
    bit [AW-1:0] a_addr;
    bit [DW-1:0] a_wdata;
    bit tc, ta, tcv, tav;   // expected c_gnt, a_gnt, c_rvalid, a_rvalid
    bit chk_rd;
    bit [DW-1:0] exp_rd;
    bit pk;                 // peek memory after this vector
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit      m_burst;
  int      m_grants;   // aux grants in current burst
  int      m_wait;     // consecutive aux denials, capped
  bit      m_rdc, m_rda;
  bit [DW-1:0] m_rdv;
  bit [DW-1:0] ref_mem [1024];

  function automatic vec_t mk(bit r, bit cr, bit cw, bit [AW-1:0] ca, bit [DW-1:0] cd,
                              bit ar, bit aw, bit al, bit [AW-1:0] aa, bit [DW-1:0] ad,
                              bit tc, bit ta, bit tcv, bit tav);
    vec_t v;
    v.rst_n = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
    v.tc = tc; v.ta = ta; v.tcv = tcv; v.tav = tav;
    v.chk_rd = 0; v.exp_rd = '0; v.pk = 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit use_tbl);
    bit eg_c, eg_a, e_we;
    bit [AW-1:0] e_addr;
    bit [DW-1:0] e_wd;
    rst_n = v.rst_n;
    bus.c_req = v.c_req; bus.c_we = v.c_we; bus.c_addr = v.c_addr; bus.c_wdata = v.c_wdata;
    bus.a_req = v.a_req; bus.a_we = v.a_we; bus.a_lock = v.a_lock;
    bus.a_addr = v.a_addr; bus.a_wdata = v.a_wdata;
    @(negedge clk);
    // arbitration rules from the model's view
    if (m_burst && v.rst_n) begin
      eg_a = v.a_req; eg_c = 0;
    end else begin
      eg_a = v.a_req && (!v.c_req || m_wait >= SMAX);
      eg_c = v.c_req && !eg_a;
    end
    e_addr = eg_a ? v.a_addr  : v.c_addr;
    e_wd   = eg_a ? v.a_wdata : v.c_wdata;
    e_we   = v.rst_n && (eg_a ? v.a_we : (eg_c && v.c_we));
    check("c_gnt",    bus.c_gnt,    eg_c);
    check("a_gnt",    bus.a_gnt,    eg_a);
    check("c_stall",  bus.c_stall,  v.c_req && !eg_c);
    check("mem_we",   bus.mem_we,   e_we);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata",bus.mem_wdata,e_wd);
    check("c_rvalid", bus.c_rvalid, m_rdc);
    check("a_rvalid", bus.a_rvalid, m_rda);
    if (m_rdc) check("c_rdata", bus.c_rdata, m_rdv);
    if (m_rda) check("a_rdata", bus.a_rdata, m_rdv);
    if (use_tbl) begin
      check("tbl_c_gnt",    bus.c_gnt,    v.tc);
      check("tbl_a_gnt",    bus.a_gnt,    v.ta);
      check("tbl_c_rvalid", bus.c_rvalid, v.tcv);
      check("tbl_a_rvalid", bus.a_rvalid, v.tav);
      if (v.chk_rd) check("tbl_rdata", bus.c_rvalid ? bus.c_rdata : bus.a_rdata, v.exp_rd);
    end
    @(posedge clk);
    if (!v.rst_n) begin
      m_burst = 0; m_grants = 0; m_wait = 0; m_rdc = 0; m_rda = 0;
    end else begin
      m_rdc = eg_c && !v.c_we;
      m_rda = eg_a && !v.a_we;
      if (m_rdc || m_rda) m_rdv = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_wd;
      if (m_burst) begin
        if (eg_a) m_grants++;
        if (!v.a_lock || !v.a_req || m_grants == BMAX) begin
          m_burst = 0; m_grants = 0; m_wait = 0;
        end
      end else begin
        m_wait = (v.a_req && !eg_a) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
        if (eg_a && v.a_lock) begin
          m_burst = 1; m_grants = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    vec_t v;
    bit prev_c;
    int k;
    for (int i = 0; i < 1024; i++) begin tmem[i] = '0; ref_mem[i] = '0; end
    m_burst = 0; m_grants = 0; m_wait = 0; m_rdc = 0; m_rda = 0; m_rdv = '0;
    rst_n = 0;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.a_req = 0; bus.a_we = 0; bus.a_lock = 0; bus.a_addr = '0; bus.a_wdata = '0;
    @(posedge clk); #1;

    // reset state, then core write/read of 0x005
    tbl.push_back(mk(0, 0,0,10'h000,16'h0000, 0,0,0,10'h000,16'h0000, 0,0,0,0));
    tbl.push_back(mk(1, 1,1,10'h005,16'h1234, 0,0,0,10'h000,16'h0000, 1,0,0,0));
    tbl.push_back(mk(1, 1,0,10'h005,16'h0000, 0,0,0,10'h000,16'h0000, 1,0,0,0));
    v = mk(1, 0,0,10'h000,16'h0000, 0,0,0,10'h000,16'h0000, 0,0,1,0);
    v.chk_rd = 1; v.exp_rd = 16'h1234; tbl.push_back(v);

    // starvation: both requesting, aux wins every 5th cycle
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 1,0,10'h020,16'h0, 1,0,0,10'h3FF,16'h0,
                       (i % 5) != 4, (i % 5) == 4,
                       (i > 0) && ((i - 1) % 5 != 4), (i > 0) && ((i - 1) % 5 == 4)));
    tbl.push_back(mk(1, 0,0,10'h000,16'h0, 0,0,0,10'h000,16'h0, 0,0,0,1));

    // burst cap: forced grant + 7 burst grants, then 4 core, then aux again
    k = 0; prev_c = 0;
    for (int j = 0; j < 17; j++) begin
      bit tc;
      tc = (j < 4) || (j >= 12 && j < 16);
      v = mk(1, 1,0,10'h030,16'h0, 1,1,1,10'(k),16'hA000 + 16'(k), tc, !tc, prev_c, 0);
      if (j == 12) v.pk = 1;
      tbl.push_back(v);
      if (!tc) k++;
      prev_c = tc;
    end
    tbl.push_back(mk(1, 0,0,10'h000,16'h0, 0,0,0,10'h000,16'h0, 0,0,0,0));

    // lock release after 3rd burst grant, core granted next cycle
    tbl.push_back(mk(1, 0,0,10'h040,16'h0, 1,1,1,10'h100,16'h0001, 0,1,0,0));
    tbl.push_back(mk(1, 0,0,10'h040,16'h0, 1,1,1,10'h101,16'h0002, 0,1,0,0));
    tbl.push_back(mk(1, 1,0,10'h040,16'h0, 1,1,0,10'h102,16'h0003, 0,1,0,0));
    tbl.push_back(mk(1, 1,0,10'h040,16'h0, 1,1,0,10'h103,16'h0004, 1,0,0,0));
    tbl.push_back(mk(1, 0,0,10'h000,16'h0, 0,0,0,10'h000,16'h0, 0,0,1,0));

    // read-after-write across ports
    tbl.push_back(mk(1, 0,0,10'h000,16'h0, 1,1,0,10'h010,16'hBEEF, 0,1,0,0));
    tbl.push_back(mk(1, 1,0,10'h010,16'h0, 0,0,0,10'h000,16'h0, 1,0,0,0));
    v = mk(1, 0,0,10'h000,16'h0, 1,0,0,10'h010,16'h0, 0,1,1,0);
    v.chk_rd = 1; v.exp_rd = 16'hBEEF; tbl.push_back(v);
    v = mk(1, 0,0,10'h000,16'h0, 0,0,0,10'h000,16'h0, 0,0,0,1);
    v.chk_rd = 1; v.exp_rd = 16'hBEEF; tbl.push_back(v);

    foreach (tbl[i]) begin
      apply(tbl[i], 1'b1);
      if (tbl[i].pk) begin
        check("mem_0x007_written", 32'(tmem[7]), 32'hA007);
        check("mem_0x008_untouched", 32'(tmem[8]), 32'h0000);
      end
    end

    // reset mid-burst with an aux read in flight
    apply(mk(1, 0,0,10'h050,16'h0,    1,0,1,10'h200,16'h0, 0,1,0,0), 1'b1);
    apply(mk(1, 0,0,10'h050,16'h0,    1,0,1,10'h201,16'h0, 0,1,0,1), 1'b1);
    apply(mk(0, 1,1,10'h050,16'h5555, 1,0,1,10'h202,16'h0, 1,0,0,1), 1'b1);
    apply(mk(1, 1,0,10'h050,16'h0,    1,0,1,10'h202,16'h0, 1,0,0,0), 1'b1);
    v = mk(1, 0,0,10'h000,16'h0, 0,0,0,10'h000,16'h0, 0,0,1,0);
    v.chk_rd = 1; v.exp_rd = 16'h0000;
    apply(v, 1'b1);
    check("no_write_in_reset", 32'(tmem[10'h050]), 32'h0000);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      v = mk(($urandom_range(63) != 0),
             ($urandom_range(9) < 7), 1'($urandom), 10'($urandom_range(15)), 16'($urandom),
             ($urandom_range(9) < 6), 1'($urandom), 1'($urandom),
             10'($urandom_range(15)), 16'($urandom), 0,0,0,0);
      apply(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
